colour_scan_sequencer: RTL and testbench
========================================

COLOUR_SCAN_SEQUENCER -- requirements
Module: colour_scan_sequencer

Interface
REQ-001 Parameter NUM_COLOURS, default 3, number of target colours scanned round-robin (2..4).
REQ-002 Parameter CONFIRM_FRAMES, default 3, consecutive hits per colour needed to report (1..7).
REQ-003 Parameter FRAME_TIMEOUT, default 100000, max clk cycles between startofpacket pulses while scanning.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; high = scanning requested.
REQ-007 startofpacket  in  1  one-cycle frame-start pulse from the camera stream.
REQ-008 flag_reached  in  1  colour_detect result for the frame just ended; valid in the startofpacket cycle.
REQ-009 colour_sel  out  2  target colour index driven to colour_detect for the current frame.
REQ-010 threshold_percent  out  7  screen-percent threshold for colour_sel, from the package table.
REQ-011 result_valid  out  1  confirmed detection available; held until accepted.
REQ-012 result_colour  out  2  confirmed colour index, stable while result_valid is high.
REQ-013 result_ready  in  1  consumer accepts the result when result_valid and result_ready are both high.
REQ-014 timeout  out  1  one-cycle pulse on frame watchdog expiry.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ARM, SCAN and REPORT.
REQ-017 IDLE->ARM when enable=1; ARM->SCAN on startofpacket, loading colour_sel=0 with no flag sample (no completed frame yet).
REQ-018 In SCAN, each startofpacket SHALL sample flag_reached for the current colour_sel, then advance colour_sel by one, wrapping NUM_COLOURS-1 -> 0.
REQ-019 colour_sel and threshold_percent SHALL be registered in the startofpacket cycle, valid from the following cycle (the first pixel of the frame).
REQ-020 Each colour SHALL have a 3-bit hit counter: +1 on a sampled hit, cleared on a sampled miss, saturating at CONFIRM_FRAMES.
REQ-021 When a hit brings a counter to CONFIRM_FRAMES, the FSM SHALL enter REPORT on the next cycle with result_colour = the sampled colour and result_valid=1.
REQ-022 In REPORT, startofpacket and flag_reached SHALL be ignored; result_valid and result_colour SHALL hold until the handshake occurs.
REQ-023 On handshake: result_valid=0, all hit counters cleared, FSM -> ARM if enable=1, else IDLE.
REQ-024 In SCAN, a watchdog SHALL count cycles since the last startofpacket; on reaching FRAME_TIMEOUT: timeout pulses for one cycle, counters clear, FSM -> ARM.
REQ-025 startofpacket in the cycle the watchdog expires SHALL take priority: no timeout, normal sample.
REQ-026 enable=0 in ARM or SCAN SHALL force IDLE on the next cycle with counters cleared; enable=0 in REPORT SHALL take effect only after the handshake.
REQ-027 threshold_percent values above 100 SHALL NOT exist in the table; threshold_percent SHALL be combinationally consistent with colour_sel at every cycle.

Reset
REQ-028 On reset: state IDLE; colour_sel=0; threshold_percent=table[0]; result_valid=0; result_colour=0; timeout=0; busy=0; all hit counters and the watchdog = 0.
REQ-029 Reset asserted in any state, including REPORT with result_valid high, SHALL override every other input in that cycle.

Structure
REQ-030 Package colour_scan_pkg SHALL hold the state enum, colour index enum (RED=0, GREEN=1, BLUE=2) and the per-colour threshold table (80, 70, 70).
REQ-031 The watchdog SHALL be a sub-module frame_watchdog (clear, run, expire pulse); all other logic SHALL reside in the top module.

Verification (NUM_COLOURS=3, CONFIRM_FRAMES=3, FRAME_TIMEOUT=100, frames 40 cycles apart)
REQ-032 Reset held 2 cycles -> all outputs at the REQ-028 values; busy=0.
REQ-033 enable=1; flag_reached=1 only at SOPs ending GREEN frames -> result_valid=1, result_colour=1 one cycle after the 9th SOP.
REQ-034 GREEN pattern hit, hit, miss, hit, hit, hit -> no report after the 2nd hit; report after the 6th GREEN frame.
REQ-035 Report pending with result_ready=0 for 10 cycles while SOPs and flags continue -> result_valid and result_colour stable; handshake -> ARM and counters zero.
REQ-036 No SOP for 100 cycles in SCAN -> timeout high for exactly one cycle, state ARM; SOP on the expiry cycle -> no timeout.
REQ-037 enable dropped mid-SCAN -> busy=0 next cycle; enable dropped during REPORT -> IDLE only after the handshake.

Source files
------------

// File: rtl/colour_scan_pkg.sv
// rtl/colour_scan_pkg.sv - shared types, widths and threshold table for the colour scan sequencer
package colour_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SCAN   = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } colour_t;

    localparam int COLOUR_W = 2;
    localparam int HIT_W    = 3;
    localparam int THRESH_W = 7;

    // Index 3 only exists when four colours are scanned; it reuses the lower threshold.
    function automatic logic [THRESH_W-1:0] threshold_for(input logic [COLOUR_W-1:0] idx);
        case (idx)
            RED:     threshold_for = 7'd80;
            GREEN:   threshold_for = 7'd70;
            BLUE:    threshold_for = 7'd70;
            default: threshold_for = 7'd70;
        endcase
    endfunction

endpackage

// File: rtl/colour_scan_sequencer_if.sv
// rtl/colour_scan_sequencer_if.sv - camera frame strobe, colour_detect select and result handshake bundle
interface colour_scan_sequencer_if;
    import colour_scan_pkg::*;

    logic                startofpacket;
    logic                flag_reached;
    logic [COLOUR_W-1:0] colour_sel;
    logic [THRESH_W-1:0] threshold_percent;
    logic                result_valid;
    logic [COLOUR_W-1:0] result_colour;
    logic                result_ready;

    modport master (
        input  startofpacket,
        input  flag_reached,
        input  result_ready,
        output colour_sel,
        output threshold_percent,
        output result_valid,
        output result_colour
    );

    modport slave (
        output startofpacket,
        output flag_reached,
        output result_ready,
        input  colour_sel,
        input  threshold_percent,
        input  result_valid,
        input  result_colour
    );

endinterface

// File: rtl/frame_watchdog.sv
// rtl/frame_watchdog.sv - counts cycles since the last frame start and flags expiry
module frame_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Expiry lands exactly TIMEOUT cycles after the clearing cycle.
    assign expire = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/colour_scan_sequencer.sv
// rtl/colour_scan_sequencer.sv - round-robin colour target scan with per-colour hit confirmation
module colour_scan_sequencer
    import colour_scan_pkg::*;
#(
    parameter int NUM_COLOURS    = 3,
    parameter int CONFIRM_FRAMES = 3,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    colour_scan_sequencer_if.master  bus,
    output logic                     timeout,
    output logic                     busy
);

    localparam logic [COLOUR_W-1:0] LAST_COLOUR = COLOUR_W'(NUM_COLOURS - 1);
    localparam logic [HIT_W-1:0]    CONFIRM_CNT = HIT_W'(CONFIRM_FRAMES);

    state_t              state;
    state_t              state_next;
    logic [COLOUR_W-1:0] colour_sel_q;
    logic [COLOUR_W-1:0] result_colour_q;
    logic                timeout_q;
    logic [HIT_W-1:0]    hit_cnt [4];
    logic [HIT_W-1:0]    cur_cnt;
    logic [HIT_W-1:0]    cur_cnt_inc;
    logic                arm_start;
    logic                sop_sample;
    logic                hit;
    logic                confirm;
    logic                handshake;
    logic                wd_clear;
    logic                wd_run;
    logic                wd_expire;
    logic                wd_timeout;
    logic                clear_hits;

    assign arm_start   = (state == ARM) && enable && bus.startofpacket;
    assign sop_sample  = (state == SCAN) && enable && bus.startofpacket;
    assign cur_cnt     = hit_cnt[colour_sel_q];
    assign cur_cnt_inc = (cur_cnt < CONFIRM_CNT) ? cur_cnt + 3'd1 : cur_cnt;
    assign hit         = sop_sample && bus.flag_reached;
    assign confirm     = hit && (cur_cnt_inc == CONFIRM_CNT);
    assign handshake   = (state == REPORT) && bus.result_ready;

    // A frame start on the expiry cycle wins: the frame is sampled and no timeout fires.
    assign wd_run     = (state == SCAN);
    assign wd_clear   = (state != SCAN) || bus.startofpacket;
    assign wd_timeout = wd_expire && enable && !bus.startofpacket;

    assign clear_hits = (state == IDLE) || (state == ARM) || handshake
                     || ((state == SCAN) && (!enable || wd_timeout));

    frame_watchdog #(
        .TIMEOUT (FRAME_TIMEOUT)
    ) u_frame_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .run    (wd_run),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable)                  state_next = IDLE;
                else if (bus.startofpacket)   state_next = SCAN;
            end
            SCAN: begin
                if (!enable)         state_next = IDLE;
                else if (confirm)    state_next = REPORT;
                else if (wd_timeout) state_next = ARM;
            end
            REPORT: begin
                if (handshake) state_next = enable ? ARM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state != IDLE);
        bus.result_valid = (state == REPORT);
    end

    assign bus.colour_sel        = colour_sel_q;
    assign bus.threshold_percent = threshold_for(colour_sel_q);
    assign bus.result_colour     = result_colour_q;
    assign timeout               = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_sel_q    <= '0;
            result_colour_q <= '0;
            timeout_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            timeout_q <= wd_timeout;

            if (arm_start) begin
                colour_sel_q <= '0;
            end else if (sop_sample) begin
                colour_sel_q <= (colour_sel_q == LAST_COLOUR) ? '0 : colour_sel_q + 2'd1;
            end

            if (confirm) begin
                result_colour_q <= colour_sel_q;
            end

            // A miss breaks the run of consecutive hits for that colour only.
            if (clear_hits) begin
                for (int i = 0; i < 4; i++) begin
                    hit_cnt[i] <= '0;
                end
            end else if (sop_sample) begin
                hit_cnt[colour_sel_q] <= hit ? cur_cnt_inc : '0;
            end
        end
    end

endmodule

// File: tb/tb_colour_scan_sequencer.sv
// tb/tb_colour_scan_sequencer.sv - randomized and directed checks against a frame-level reference model
module tb_colour_scan_sequencer;

    localparam int NC  = 3;
    localparam int CF  = 3;
    localparam int FT  = 100;
    localparam int GAP = 40;

    localparam int M_IDLE   = 0;
    localparam int M_ARM    = 1;
    localparam int M_SCAN   = 2;
    localparam int M_REPORT = 3;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic timeout;
    logic busy;

    colour_scan_sequencer_if bus ();

    colour_scan_sequencer #(
        .NUM_COLOURS    (NC),
        .CONFIRM_FRAMES (CF),
        .FRAME_TIMEOUT  (FT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus.master),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int     m_mode;
    int     m_cur;
    int     m_rc;
    int     m_hits [NC];
    bit     m_to;
    longint cyc = 0;
    longint last_sop = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int thr(input int c);
        case (c)
            0:       return 80;
            1:       return 70;
            default: return 70;
        endcase
    endfunction

    function automatic void clear_hits();
        for (int i = 0; i < NC; i++) m_hits[i] = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit en, input bit sop, input bit flag, input bit rdy);
        if (rst) begin
            m_mode = M_IDLE; m_cur = 0; m_rc = 0; m_to = 0;
            clear_hits();
            return;
        end
        m_to = 0;
        case (m_mode)
            M_IDLE: begin
                clear_hits();
                if (en) m_mode = M_ARM;
            end
            M_ARM: begin
                clear_hits();
                if (!en) m_mode = M_IDLE;
                else if (sop) begin
                    m_mode = M_SCAN; m_cur = 0; last_sop = cyc;
                end
            end
            M_SCAN: begin
                if (!en) begin
                    m_mode = M_IDLE; clear_hits();
                end else if (sop) begin
                    last_sop = cyc;
                    if (flag) begin
                        if (m_hits[m_cur] < CF) m_hits[m_cur]++;
                        if (m_hits[m_cur] == CF) begin
                            m_mode = M_REPORT; m_rc = m_cur;
                        end
                    end else begin
                        m_hits[m_cur] = 0;
                    end
                    m_cur = (m_cur + 1) % NC;
                end else if (cyc - last_sop == FT) begin
                    m_to = 1; m_mode = M_ARM; clear_hits();
                end
            end
            default: begin
                if (rdy) begin
                    m_mode = en ? M_ARM : M_IDLE; clear_hits();
                end
            end
        endcase
    endfunction

    task automatic tick(input bit rst, input bit sop, input bit flag);
        reset             = rst;
        bus.startofpacket = sop;
        bus.flag_reached  = flag;
        @(posedge clk);
        cyc++;
        model_step(rst, enable, sop, flag, bus.result_ready);
        #1;
        check_eq("colour_sel",    32'(bus.colour_sel),        32'(m_cur));
        check_eq("threshold",     32'(bus.threshold_percent), 32'(thr(m_cur)));
        check_eq("result_valid",  32'(bus.result_valid),      32'(m_mode == M_REPORT));
        check_eq("result_colour", 32'(bus.result_colour),     32'(m_rc));
        check_eq("timeout",       32'(timeout),               32'(m_to));
        check_eq("busy",          32'(busy),                  32'(m_mode != M_IDLE));
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic drive_to_report();
        for (int i = 0; i < 200 && m_mode != M_REPORT; i++) tick(0, 1, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int n_sop;
        int gi;
        int gap;
        bit pat [6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        enable = 0; bus.result_ready = 0;
        bus.startofpacket = 0; bus.flag_reached = 0; reset = 1;
        tick(1, 0, 0);
        tick(1, 0, 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_valid", 32'(bus.result_valid), 0);
        check_eq("rst_sel",   32'(bus.colour_sel), 0);
        check_eq("rst_thr",   32'(bus.threshold_percent), 80);

        // Hits only on GREEN frames: report one cycle after the 9th frame start.
        enable = 1;
        tick(0, 0, 0);
        n_sop = 0;
        while (n_sop < 9) begin
            tick(0, 1, (m_mode == M_SCAN) && (m_cur == 1));
            n_sop++;
            if (n_sop == 8) check_eq("green_no_early", 32'(bus.result_valid), 0);
            if (n_sop < 9) idle_ticks(GAP - 1);
        end
        check_eq("green_valid",  32'(bus.result_valid), 1);
        check_eq("green_colour", 32'(bus.result_colour), 1);

        // Stall the consumer while frames keep arriving.
        for (int i = 0; i < 12; i++) begin
            tick(0, ($urandom % 3) == 0, $urandom % 2);
            check_eq("stall_valid",  32'(bus.result_valid), 1);
            check_eq("stall_colour", 32'(bus.result_colour), 1);
        end
        bus.result_ready = 1;
        tick(0, 0, 0);
        bus.result_ready = 0;
        check_eq("hs_valid_low", 32'(bus.result_valid), 0);
        check_eq("hs_busy_arm",  32'(busy), 1);

        // GREEN hit, hit, miss, hit, hit, hit.
        gi = 0;
        for (int f = 0; f < 40 && gi < 6; f++) begin
            if (m_mode == M_SCAN && m_cur == 1) begin
                tick(0, 1, pat[gi]);
                gi++;
                if (gi == 2) check_eq("pat_no_report_2", 32'(bus.result_valid), 0);
                if (gi == 5) check_eq("pat_no_report_5", 32'(bus.result_valid), 0);
            end else begin
                tick(0, 1, 0);
            end
            if (gi < 6) idle_ticks(GAP - 1);
        end
        check_eq("pat_report",        32'(bus.result_valid), 1);
        check_eq("pat_report_colour", 32'(bus.result_colour), 1);
        bus.result_ready = 1;
        tick(0, 0, 0);
        bus.result_ready = 0;

        // Watchdog expiry, then a frame start landing exactly on the expiry cycle.
        tick(0, 1, 0);
        idle_ticks(FT - 1);
        check_eq("wd_before", 32'(timeout), 0);
        tick(0, 0, 0);
        check_eq("wd_pulse", 32'(timeout), 1);
        check_eq("wd_busy",  32'(busy), 1);
        tick(0, 0, 0);
        check_eq("wd_one_cycle", 32'(timeout), 0);
        tick(0, 1, 0);
        idle_ticks(FT - 1);
        tick(0, 1, 0);
        check_eq("wd_sop_prio",   32'(timeout), 0);
        check_eq("wd_sop_sample", 32'(bus.colour_sel), 1);
        idle_ticks(3);

        // Enable dropped mid-scan.
        enable = 0;
        tick(0, 0, 0);
        check_eq("en_drop_scan_busy", 32'(busy), 0);

        // Enable dropped during a pending report.
        enable = 1;
        tick(0, 0, 0);
        drive_to_report();
        check_eq("rep_reached", 32'(bus.result_valid), 1);
        enable = 0;
        idle_ticks(5);
        check_eq("rep_hold_busy",  32'(busy), 1);
        check_eq("rep_hold_valid", 32'(bus.result_valid), 1);
        bus.result_ready = 1;
        tick(0, 0, 0);
        bus.result_ready = 0;
        check_eq("rep_exit_idle", 32'(busy), 0);

        // Reset overrides a pending report and a simultaneous handshake.
        enable = 1;
        tick(0, 0, 0);
        drive_to_report();
        bus.result_ready = 1;
        tick(1, 1, 1);
        bus.result_ready = 0;
        check_eq("rst_in_report_valid", 32'(bus.result_valid), 0);
        check_eq("rst_in_report_busy",  32'(busy), 0);

        // Randomized traffic.
        gap = 1;
        for (int i = 0; i < 5000; i++) begin
            enable           = ($urandom % 60) != 0;
            bus.result_ready = ($urandom % 4) == 0;
            gap--;
            if (gap <= 0) begin
                gap = (($urandom % 5) == 0) ? int'($urandom_range(95, 110)) : int'($urandom_range(1, 50));
                tick(($urandom % 700) == 0, 1, $urandom % 2);
            end else begin
                tick(($urandom % 700) == 0, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
